// File: rtl/lighthouse_bmc_decoder.sv
// Lighthouse TS4231 front end: timestamps each light hit and decodes its 17-bit biphase-mark payload.
// Optional feature macro LIGHTHOUSE_ERROR_COUNT_EN adds a saturating decode-error counter output.
module lighthouse_bmc_decoder #(
  parameter int SHORT_MAX = 3,
  parameter int LONG_MAX  = 6,
  parameter int NBITS     = 17
) (
  input  logic             clk_12MHz,
  input  logic             reset,
  input  logic             envelope,
  input  logic             data_in,
  input  logic             reset_decoder,
  output logic             data_availible,
  output logic [NBITS-1:0] decoded_data,
  output logic [23:0]      timestamp_last_data
`ifdef LIGHTHOUSE_ERROR_COUNT_EN
  ,
  output logic [7:0]       error_count
`endif
);

  localparam int IW = $clog2(LONG_MAX + 2);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [IW-1:0] INT_SAT   = IW'(LONG_MAX + 1);
  localparam logic [IW:0]   SHORT_LIM = (IW+1)'(SHORT_MAX);
  localparam logic [IW:0]   LONG_LIM  = (IW+1)'(LONG_MAX);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DECODE,
    DONE,
    WAIT_ENV_END
  } state_t;

  state_t state, state_next;

  logic [2:0]       env_sync, dat_sync;
  logic             env_hi, env_fall, data_edge;
  logic [23:0]      ts_cnt, ts_pending;
  logic [IW-1:0]    int_cnt;
  logic [IW:0]      interval;
  logic [BW-1:0]    bit_cnt;
  logic             half_pending;
  logic [NBITS-1:0] shift_reg, shift_next;
  logic             is_short, is_long, bit_done, decode_err;

  // Bits [1:0] are the two-stage synchroniser; bit [2] is the previous synchronised level for edge detection.
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      env_sync <= '0;
      dat_sync <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      env_sync <= {env_sync[1:0], envelope};
      dat_sync <= {dat_sync[1:0], data_in};
    end
  end

  assign env_hi    = env_sync[1];
  assign env_fall  = env_sync[2] & ~env_sync[1];
  assign data_edge = env_sync[0] ^ env_sync[0] ^ (dat_sync[2] ^ dat_sync[1]);

  // Interval in cycles since the previous data edge (counter is cleared in the edge cycle).
  assign interval   = {1'b0, int_cnt} + (IW+1)'(1);
  assign shift_next = {shift_reg[NBITS-2:0], is_short};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    is_short   = 1'b0;
    is_long    = 1'b0;
    bit_done   = 1'b0;
    decode_err = 1'b0;
    is_short   = (interval <= SHORT_LIM);
    is_long    = (interval > SHORT_LIM) && (interval <= LONG_LIM);
    bit_done   = data_edge && ((is_short && half_pending) || (is_long && !half_pending));
    if (data_edge) begin
      decode_err = !(is_short || (is_long && !half_pending));
    end else begin
      decode_err = (int_cnt == INT_SAT) || env_hi;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next-state logic; a data edge wins over a simultaneous envelope release.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (env_fall) state_next = SYNC;
      SYNC: begin
        if (data_edge)   state_next = DECODE;
        else if (env_hi) state_next = IDLE;
      end
      DECODE: begin
        if (decode_err)                          state_next = WAIT_ENV_END;
        else if (bit_done && bit_cnt == LAST_BIT) state_next = DONE;
      end
      DONE:         if (reset_decoder) state_next = WAIT_ENV_END;
      WAIT_ENV_END: if (env_hi) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    data_availible = (state == DONE);
  end

  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      ts_cnt              <= '0;
      ts_pending          <= '0;
      int_cnt             <= '0;
      bit_cnt             <= '0;
      half_pending        <= 1'b0;
      shift_reg           <= '0;
      decoded_data        <= '0;
      timestamp_last_data <= '0;
    end else begin
      ts_cnt <= ts_cnt + 24'd1;

      if (data_edge) begin
        int_cnt <= '0;
      end else if (int_cnt != INT_SAT) begin
        int_cnt <= int_cnt + IW'(1);
      end

      if (state == IDLE && env_fall) begin
        ts_pending   <= ts_cnt;
        bit_cnt      <= '0;
        half_pending <= 1'b0;
      end

      if (state == DECODE && data_edge && !decode_err) begin
        if (!bit_done) begin
          half_pending <= 1'b1;
        end else begin
          half_pending <= 1'b0;
          shift_reg    <= shift_next;
          bit_cnt      <= bit_cnt + BW'(1);
          // Result registers change only on a completed frame, so errors leave them untouched.
          if (bit_cnt == LAST_BIT) begin
            decoded_data        <= shift_next;
            timestamp_last_data <= ts_pending;
          end
        end
      end
    end
  end

`ifdef LIGHTHOUSE_ERROR_COUNT_EN
  always_ff @(posedge clk_12MHz or posedge reset) begin
    if (reset) begin
      error_count <= '0;
    end else if (state == DECODE && decode_err && error_count != 8'hFF) begin
      error_count <= error_count + 8'd1;
    end
  end
`endif

endmodule
